// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the ID/EXE pipeline slice.
//   - default datapath and register-address widths
//   - BR_Type codes and the EXE_CMD no-op code
//   - ctrl_t: the control bundle that travels with an instruction
//   - gate_ctrl(): turns a control bundle into a bubble when the slot is empty
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    // Branch type codes; BR_NONE must stay all-zero so a cleared register
    // reads as "no branch".
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    // ALU command no-op; all-zero for the same reason as BR_NONE.
    localparam logic [3:0] EXE_CMD_NOP = 4'b0000;

    typedef struct packed {
        logic [1:0] br_type;
        logic [3:0] exe_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        br_type:  BR_NONE,
        exe_cmd:  EXE_CMD_NOP,
        mem_r_en: 1'b0,
        mem_w_en: 1'b0,
        wb_en:    1'b0
    };

    // An empty slot must never carry side-effecting control downstream.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
        return valid ? c : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-high reset.
//   clk   - clock, rising edge
//   rst   - synchronous clear
//   inc   - add one this edge (ignored once the counter is at all-ones)
//   count - current value, CNT_W bits
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register with stall/flush and statistics.
//   clk, rst            - clock, synchronous active-high reset
//   freeze              - hold current contents (hazard stall)
//   flush               - next contents become a bubble (wins over freeze)
//   in_valid            - ID slot holds a real instruction
//   PC_in, Val1_in, Val2_in, Reg2_in     - DATA_W data fields
//   Dest_in, Src1_in, Src2_in            - REG_AW register numbers
//   BR_Type_in, EXE_CMD_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in - control
//   *_out               - registered copies of the above, 1-cycle latency
//   valid_out, bubble   - slot occupancy and its complement
//   stall_cnt, flush_cnt - saturating event counters
module id_exe_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [REG_AW-1:0] Dest_in,
    input  logic [REG_AW-1:0] Src1_in,
    input  logic [REG_AW-1:0] Src2_in,
    input  logic [DATA_W-1:0] Val1_in,
    input  logic [DATA_W-1:0] Val2_in,
    input  logic [DATA_W-1:0] Reg2_in,
    input  logic [1:0]        BR_Type_in,
    input  logic [3:0]        EXE_CMD_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              WB_EN_in,
    output logic [DATA_W-1:0] PC_out,
    output logic [REG_AW-1:0] Dest_out,
    output logic [REG_AW-1:0] Src1_out,
    output logic [REG_AW-1:0] Src2_out,
    output logic [DATA_W-1:0] Val1_out,
    output logic [DATA_W-1:0] Val2_out,
    output logic [DATA_W-1:0] Reg2_out,
    output logic [1:0]        BR_Type_out,
    output logic [3:0]        EXE_CMD_out,
    output logic              MEM_R_EN_out,
    output logic              MEM_W_EN_out,
    output logic              WB_EN_out,
    output logic              valid_out,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [DATA_W-1:0] pc_q,   pc_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [REG_AW-1:0] src1_q, src1_d;
    logic [REG_AW-1:0] src2_q, src2_d;
    logic [DATA_W-1:0] val1_q, val1_d;
    logic [DATA_W-1:0] val2_q, val2_d;
    logic [DATA_W-1:0] reg2_q, reg2_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;

    ctrl_t ctrl_in;
    logic  stall_inc;
    logic  flush_inc;

    assign ctrl_in = '{
        br_type:  BR_Type_in,
        exe_cmd:  EXE_CMD_in,
        mem_r_en: MEM_R_EN_in,
        mem_w_en: MEM_W_EN_in,
        wb_en:    WB_EN_in
    };

    // Priority below rst (handled in the flop): flush, then freeze, then load.
    always_comb begin
        pc_d    = pc_q;
        dest_d  = dest_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        reg2_d  = reg2_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;

        if (flush) begin
            pc_d    = '0;
            dest_d  = '0;
            src1_d  = '0;
            src2_d  = '0;
            val1_d  = '0;
            val2_d  = '0;
            reg2_d  = '0;
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end else if (!freeze) begin
            // Data fields are captured even for an empty slot; only the
            // control bundle is forced to a bubble.
            pc_d    = PC_in;
            dest_d  = Dest_in;
            src1_d  = Src1_in;
            src2_d  = Src2_in;
            val1_d  = Val1_in;
            val2_d  = Val2_in;
            reg2_d  = Reg2_in;
            ctrl_d  = gate_ctrl(ctrl_in, in_valid);
            valid_d = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            dest_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            reg2_q  <= '0;
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            dest_q  <= dest_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
            reg2_q  <= reg2_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign PC_out       = pc_q;
    assign Dest_out     = dest_q;
    assign Src1_out     = src1_q;
    assign Src2_out     = src2_q;
    assign Val1_out     = val1_q;
    assign Val2_out     = val2_q;
    assign Reg2_out     = reg2_q;
    assign BR_Type_out  = ctrl_q.br_type;
    assign EXE_CMD_out  = ctrl_q.exe_cmd;
    assign MEM_R_EN_out = ctrl_q.mem_r_en;
    assign MEM_W_EN_out = ctrl_q.mem_w_en;
    assign WB_EN_out    = ctrl_q.wb_en;
    assign valid_out    = valid_q;
    assign bubble       = ~valid_q;

    // A stall only counts when it is actually holding a live instruction;
    // a flush always counts, even when freeze is also asserted.
    assign stall_inc = freeze & ~flush & valid_q;
    assign flush_inc = flush;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_id_exe_reg.sv
module tb_id_exe_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          freeze;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] PC_in, Val1_in, Val2_in, Reg2_in;
    logic [AW-1:0] Dest_in, Src1_in, Src2_in;
    logic [1:0]    BR_Type_in;
    logic [3:0]    EXE_CMD_in;
    logic          MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
    logic [DW-1:0] PC_out, Val1_out, Val2_out, Reg2_out;
    logic [AW-1:0] Dest_out, Src1_out, Src2_out;
    logic [1:0]    BR_Type_out;
    logic [3:0]    EXE_CMD_out;
    logic          MEM_R_EN_out, MEM_W_EN_out, WB_EN_out;
    logic          valid_out, bubble;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    id_exe_reg #(
        .DATA_W (DW),
        .REG_AW (AW),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .in_valid     (in_valid),
        .PC_in        (PC_in),
        .Dest_in      (Dest_in),
        .Src1_in      (Src1_in),
        .Src2_in      (Src2_in),
        .Val1_in      (Val1_in),
        .Val2_in      (Val2_in),
        .Reg2_in      (Reg2_in),
        .BR_Type_in   (BR_Type_in),
        .EXE_CMD_in   (EXE_CMD_in),
        .MEM_R_EN_in  (MEM_R_EN_in),
        .MEM_W_EN_in  (MEM_W_EN_in),
        .WB_EN_in     (WB_EN_in),
        .PC_out       (PC_out),
        .Dest_out     (Dest_out),
        .Src1_out     (Src1_out),
        .Src2_out     (Src2_out),
        .Val1_out     (Val1_out),
        .Val2_out     (Val2_out),
        .Reg2_out     (Reg2_out),
        .BR_Type_out  (BR_Type_out),
        .EXE_CMD_out  (EXE_CMD_out),
        .MEM_R_EN_out (MEM_R_EN_out),
        .MEM_W_EN_out (MEM_W_EN_out),
        .WB_EN_out    (WB_EN_out),
        .valid_out    (valid_out),
        .bubble       (bubble),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic v, input logic [31:0] pc, input logic [4:0] dst,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] r2,
                              input logic [1:0] br, input logic [3:0] cmd,
                              input logic mr, input logic mw, input logic wb);
        in_valid    = v;
        PC_in       = pc;
        Dest_in     = dst;
        Src1_in     = s1;
        Src2_in     = s2;
        Val1_in     = v1;
        Val2_in     = v2;
        Reg2_in     = r2;
        BR_Type_in  = br;
        EXE_CMD_in  = cmd;
        MEM_R_EN_in = mr;
        MEM_W_EN_in = mw;
        WB_EN_in    = wb;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".pc"},    PC_out, 32'h0);
        chk({tag, ".dest"},  32'(Dest_out), 32'h0);
        chk({tag, ".src1"},  32'(Src1_out), 32'h0);
        chk({tag, ".src2"},  32'(Src2_out), 32'h0);
        chk({tag, ".val1"},  Val1_out, 32'h0);
        chk({tag, ".val2"},  Val2_out, 32'h0);
        chk({tag, ".reg2"},  Reg2_out, 32'h0);
        chk({tag, ".br"},    32'(BR_Type_out), 32'h0);
        chk({tag, ".cmd"},   32'(EXE_CMD_out), 32'h0);
        chk({tag, ".mr"},    32'(MEM_R_EN_out), 32'h0);
        chk({tag, ".mw"},    32'(MEM_W_EN_out), 32'h0);
        chk({tag, ".wb"},    32'(WB_EN_out), 32'h0);
        chk({tag, ".valid"}, 32'(valid_out), 32'h0);
        chk({tag, ".bubble"}, 32'(bubble), 32'h1);
    endtask

    initial begin
        // Reset overrides flush/freeze and a live input on the same edge.
        rst = 1'b1; flush = 1'b1; freeze = 1'b1;
        set_inputs(1'b1, 32'hFFFF_0000, 5'd31, 5'd30, 5'd29, 32'h1, 32'h2, 32'h3,
                   2'b11, 4'hF, 1'b1, 1'b1, 1'b1);
        step();
        step();
        chk_cleared("reset");
        chk("reset.stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset.flush_cnt", 32'(flush_cnt), 32'h0);

        // First edge with rst low performs a load.
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        set_inputs(1'b1, 32'h0000_0010, 5'd3, 5'd1, 5'd2, 32'h5, 32'h22, 32'h33,
                   2'b00, 4'h1, 1'b0, 1'b0, 1'b1);
        step();
        chk("load.pc",     PC_out, 32'h10);
        chk("load.val1",   Val1_out, 32'h5);
        chk("load.val2",   Val2_out, 32'h22);
        chk("load.reg2",   Reg2_out, 32'h33);
        chk("load.dest",   32'(Dest_out), 32'd3);
        chk("load.src1",   32'(Src1_out), 32'd1);
        chk("load.src2",   32'(Src2_out), 32'd2);
        chk("load.cmd",    32'(EXE_CMD_out), 32'h1);
        chk("load.wb",     32'(WB_EN_out), 32'h1);
        chk("load.mw",     32'(MEM_W_EN_out), 32'h0);
        chk("load.valid",  32'(valid_out), 32'h1);
        chk("load.bubble", 32'(bubble), 32'h0);

        // Freeze three cycles while inputs change.
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, 32'h100 + 32'(i), 5'd7, 5'd8, 5'd9, 32'hDEAD_0000 + 32'(i),
                       32'h77, 32'h88, 2'b10, 4'h9, 1'b1, 1'b1, 1'b0);
            step();
            chk("freeze.pc",    PC_out, 32'h10);
            chk("freeze.val1",  Val1_out, 32'h5);
            chk("freeze.dest",  32'(Dest_out), 32'd3);
            chk("freeze.wb",    32'(WB_EN_out), 32'h1);
            chk("freeze.mr",    32'(MEM_R_EN_out), 32'h0);
            chk("freeze.valid", 32'(valid_out), 32'h1);
            chk("freeze.stall_cnt", 32'(stall_cnt), 32'(i + 1));
            chk("freeze.flush_cnt", 32'(flush_cnt), 32'h0);
        end

        // Flush together with freeze: flush wins.
        flush = 1'b1; freeze = 1'b1;
        set_inputs(1'b1, 32'h200, 5'd4, 5'd5, 5'd6, 32'hAA, 32'hBB, 32'hCC,
                   2'b01, 4'hF, 1'b1, 1'b1, 1'b1);
        step();
        chk_cleared("flush");
        chk("flush.flush_cnt", 32'(flush_cnt), 32'd1);
        chk("flush.stall_cnt", 32'(stall_cnt), 32'd3);

        // Freeze over a bubble does not count as a stall.
        flush = 1'b0; freeze = 1'b1;
        step();
        chk("frzbub.valid",     32'(valid_out), 32'h0);
        chk("frzbub.pc",        PC_out, 32'h0);
        chk("frzbub.stall_cnt", 32'(stall_cnt), 32'd3);

        // Load an empty slot: control zeroed, data captured.
        freeze = 1'b0;
        set_inputs(1'b0, 32'h44, 5'd9, 5'd10, 5'd11, 32'hAB, 32'hCD, 32'hEF,
                   2'b01, 4'h5, 1'b1, 1'b1, 1'b1);
        step();
        chk("empty.mr",     32'(MEM_R_EN_out), 32'h0);
        chk("empty.br",     32'(BR_Type_out), 32'h0);
        chk("empty.valid",  32'(valid_out), 32'h0);
        chk("empty.bubble", 32'(bubble), 32'h1);
        chk("empty.wb",     32'(WB_EN_out), 32'h0);
        chk("empty.mw",     32'(MEM_W_EN_out), 32'h0);
        chk("empty.cmd",    32'(EXE_CMD_out), 32'h0);
        chk("empty.pc",     PC_out, 32'h44);
        chk("empty.val1",   Val1_out, 32'hAB);
        chk("empty.dest",   32'(Dest_out), 32'd9);
        chk("empty.reg2",   Reg2_out, 32'hEF);

        // Live instruction with every control bit set.
        set_inputs(1'b1, 32'h48, 5'd31, 5'd30, 5'd29, 32'h11, 32'h2222_2222, 32'h99,
                   2'b10, 4'hA, 1'b1, 1'b1, 1'b1);
        step();
        chk("full.pc",    PC_out, 32'h48);
        chk("full.dest",  32'(Dest_out), 32'd31);
        chk("full.src1",  32'(Src1_out), 32'd30);
        chk("full.src2",  32'(Src2_out), 32'd29);
        chk("full.val1",  Val1_out, 32'h11);
        chk("full.val2",  Val2_out, 32'h2222_2222);
        chk("full.reg2",  Reg2_out, 32'h99);
        chk("full.br",    32'(BR_Type_out), 32'h2);
        chk("full.cmd",   32'(EXE_CMD_out), 32'hA);
        chk("full.mr",    32'(MEM_R_EN_out), 32'h1);
        chk("full.mw",    32'(MEM_W_EN_out), 32'h1);
        chk("full.wb",    32'(WB_EN_out), 32'h1);
        chk("full.valid", 32'(valid_out), 32'h1);

        // Stall counter saturation (starts at 3, 4-bit counter).
        freeze = 1'b1;
        set_inputs(1'b1, 32'h999, 5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 32'h1,
                   2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("sat.stall_cnt", 32'(stall_cnt), (3 + i + 1 > 15) ? 32'd15 : 32'(3 + i + 1));
        end
        chk("sat.pc_held", PC_out, 32'h48);
        chk("sat.wb_held", 32'(WB_EN_out), 32'h1);

        // Flush counter saturation (starts at 1), freeze toggling.
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            freeze = i[0];
            step();
            chk("fsat.flush_cnt", 32'(flush_cnt), (1 + i + 1 > 15) ? 32'd15 : 32'(1 + i + 1));
        end
        chk("fsat.stall_cnt", 32'(stall_cnt), 32'd15);
        chk("fsat.valid",     32'(valid_out), 32'h0);

        // Reset in the middle of a freeze with stall_cnt = 7.
        flush = 1'b0; freeze = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        set_inputs(1'b1, 32'h60, 5'd2, 5'd3, 5'd4, 32'h66, 32'h67, 32'h68,
                   2'b00, 4'h3, 1'b0, 1'b0, 1'b1);
        step();
        chk("rst2.load_valid", 32'(valid_out), 32'h1);
        freeze = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("rst2.stall7", 32'(stall_cnt), 32'd7);
        rst = 1'b1;
        step();
        chk_cleared("midrst");
        chk("midrst.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst.flush_cnt", 32'(flush_cnt), 32'd0);

        rst = 1'b0; freeze = 1'b0;
        set_inputs(1'b1, 32'h70, 5'd5, 5'd6, 5'd7, 32'h77, 32'h78, 32'h79,
                   2'b11, 4'h6, 1'b0, 1'b1, 1'b0);
        step();
        chk("resume.pc",        PC_out, 32'h70);
        chk("resume.val1",      Val1_out, 32'h77);
        chk("resume.br",        32'(BR_Type_out), 32'h3);
        chk("resume.mw",        32'(MEM_W_EN_out), 32'h1);
        chk("resume.valid",     32'(valid_out), 32'h1);
        chk("resume.stall_cnt", 32'(stall_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of Val1/Val2/Reg2/PC fields.
REQ-002 Parameter REG_AW, default 5, register-address width of Dest/Src1/Src2.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 freeze  input  1  stall request from hazard unit; hold current contents.
REQ-007 flush  input  1  branch-taken kill; next contents become a bubble.
REQ-008 in_valid  input  1  ID slot holds a real instruction.
REQ-009 PC_in  input  DATA_W  PC+4 of the ID instruction.
REQ-010 Dest_in, Src1_in, Src2_in  input  REG_AW each  destination and source register numbers.
REQ-011 Val1_in, Val2_in, Reg2_in  input  DATA_W each  operands from ID.
REQ-012 BR_Type_in  input  2; EXE_CMD_in  input  4; MEM_R_EN_in, MEM_W_EN_in, WB_EN_in  input  1 each.
REQ-013 Outputs mirror REQ-009..REQ-012 with suffix _out instead of _in, same widths, plus valid_out  output  1.
REQ-014 bubble  output  1  equals !valid_out, combinational.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  saturating statistics counters.

Function
REQ-016 Register update priority per rising edge SHALL be: rst, then flush, then freeze, then load.
REQ-017 Load (no rst/flush/freeze) SHALL capture every _in field into its _out and set valid_out=in_valid; latency exactly 1 cycle.
REQ-018 Load with in_valid=0 SHALL zero WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, BR_Type_out, EXE_CMD_out; data fields still captured.
REQ-019 Freeze (flush=0) SHALL hold all _out fields and valid_out unchanged.
REQ-020 Flush SHALL set valid_out=0, all control outputs (WB_EN, MEM_R_EN, MEM_W_EN, BR_Type, EXE_CMD) to 0, Dest/Src1/Src2 to 0, data and PC fields to 0.
REQ-021 Flush and freeze asserted together SHALL act as flush (bubble wins; a stalled killed instruction never reaches EXE).
REQ-022 A bubble SHALL never write state downstream: WB_EN_out=MEM_W_EN_out=0 whenever valid_out=0.
REQ-023 stall_cnt SHALL increment by 1 on each edge with freeze=1, flush=0, valid_out=1, rst=0.
REQ-024 flush_cnt SHALL increment by 1 on each edge with flush=1, rst=0, regardless of freeze.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and hold there; no wrap-around.
REQ-026 BR_Type encoding 2'b00 SHALL mean no branch; EXE_CMD 4'b0000 SHALL mean no-op.

Reset
REQ-027 rst=1 at a rising edge SHALL clear all _out fields, valid_out, stall_cnt, flush_cnt to 0 (bubble=1).
REQ-028 rst SHALL override flush/freeze and in-flight contents on the same edge; first load occurs on the first edge with rst=0.

Structure
REQ-029 Shared package mips_pkg SHALL hold DATA_W/REG_AW defaults, BR_Type codes and the EXE_CMD no-op code.
REQ-030 One sub-module sat_counter (parameter CNT_W; inputs clk, rst, inc; output count) SHALL be instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-031 After rst, load PC_in=0x00000010, Val1_in=0x5, Dest_in=3, WB_EN_in=1, in_valid=1 -> next cycle outputs equal inputs, valid_out=1, bubble=0.
REQ-032 Hold freeze=1 for 3 cycles with changing inputs -> outputs unchanged, stall_cnt=3, flush_cnt=0.
REQ-033 flush=1 and freeze=1 same cycle with WB_EN_in=1, MEM_W_EN_in=1 -> next cycle valid_out=0, WB_EN_out=0, MEM_W_EN_out=0, EXE_CMD_out=0, flush_cnt=1, stall_cnt unchanged.
REQ-034 CNT_W=4, freeze=1 with valid_out=1 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-035 rst=1 mid-freeze with stall_cnt=7 -> next cycle all outputs 0, stall_cnt=0, bubble=1; load resumes the cycle after rst falls.
REQ-036 in_valid=0 with MEM_R_EN_in=1, BR_Type_in=2'b01 -> next cycle MEM_R_EN_out=0, BR_Type_out=0, valid_out=0.
